// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared widths, the hard-wired zero register and the write-port grant encoding
// for the register-file write-port arbiter.
package regfile_wport_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    GntNone,
    GntWb,
    GntDrain,
    GntBypass
  } wport_gnt_e;

endpackage

// File: rtl/wport_pending_fifo.sv
// Circular buffer of pending long-latency writes with per-entry live bits,
// broadcast kill-by-address and two address-match (CAM) query outputs.
module wport_pending_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_wa,
  input  logic [DATA_W-1:0] i_push_wd,
  input  logic              i_push_live,
  input  logic              i_pop,
  input  logic              i_kill,
  input  logic [ADDR_W-1:0] i_kill_wa,
  input  logic [ADDR_W-1:0] i_q_rs,
  input  logic [ADDR_W-1:0] i_q_rt,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_head_live,
  output logic [ADDR_W-1:0] o_head_wa,
  output logic [DATA_W-1:0] o_head_wd,
  output logic              o_match_rs,
  output logic              o_match_rt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_wa [DEPTH];
  logic [DATA_W-1:0] r_wd [DEPTH];
  logic [DEPTH-1:0]  r_live;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DEPTH-1:0]  w_live_d;

  // Popped slots drop their live bit so live always implies occupied.
  always_comb begin
    w_live_d = r_live;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_kill && (r_wa[i] == i_kill_wa)) w_live_d[i] = 1'b0;
    end
    if (i_pop)  w_live_d[r_rd_ptr] = 1'b0;
    if (i_push) w_live_d[r_wr_ptr] = i_push_live;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_live   <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_live <= w_live_d;
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_wa[r_wr_ptr] <= i_push_wa;
      r_wd[r_wr_ptr] <= i_push_wd;
    end
  end

  always_comb begin
    o_match_rs = 1'b0;
    o_match_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] && (r_wa[i] == i_q_rs) && (i_q_rs != REG_ZERO)) o_match_rs = 1'b1;
      if (r_live[i] && (r_wa[i] == i_q_rt) && (i_q_rt != REG_ZERO)) o_match_rt = 1'b1;
    end
  end

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_head_live = r_live[r_rd_ptr];
  assign o_head_wa   = r_wa[r_rd_ptr];
  assign o_head_wd   = r_wd[r_rd_ptr];

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the register-file write port between writeback (always first) and a
// queue of long-latency results drained into idle cycles, with starvation stall.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_wa,
  input  logic [31:0] i_wb_wd,
  input  logic        i_ll_valid,
  input  logic [4:0]  i_ll_wa,
  input  logic [31:0] i_ll_wd,
  output logic        o_ll_ready,
  input  logic [4:0]  i_q_rs,
  input  logic [4:0]  i_q_rt,
  output logic        o_pend_rs,
  output logic        o_pend_rt,
  output logic        o_stall_req,
  output logic        o_we,
  output logic [4:0]  o_wa,
  output logic [31:0] o_wd
);

  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  wport_gnt_e        w_gnt;
  logic              w_wb_req;
  logic              w_ll_req;
  logic              w_empty;
  logic              w_full;
  logic              w_head_live;
  logic [ADDR_W-1:0] w_head_wa;
  logic [DATA_W-1:0] w_head_wd;
  logic              w_push;
  logic              w_push_live;
  logic [STV_W-1:0]  r_starve_cnt;
  logic [STV_W-1:0]  w_starve_cnt_d;
  logic              r_stall_req;
  logic              w_stall_req_d;

  // Register zero is never a write target on either path.
  assign w_wb_req = i_wb_we && (i_wb_wa != REG_ZERO);
  assign w_ll_req = i_ll_valid && (i_ll_wa != REG_ZERO);

  always_comb begin
    w_gnt = GntNone;
    if (!i_rst) begin
      if (w_wb_req)      w_gnt = GntWb;
      else if (!w_empty) w_gnt = GntDrain;
      else if (w_ll_req) w_gnt = GntBypass;
    end
  end

  always_comb begin
    o_we = 1'b0;
    o_wa = REG_ZERO;
    o_wd = '0;
    unique case (w_gnt)
      GntWb: begin
        o_we = 1'b1;
        o_wa = i_wb_wa;
        o_wd = i_wb_wd;
      end
      GntDrain: begin
        if (w_head_live) begin
          o_we = 1'b1;
          o_wa = w_head_wa;
          o_wd = w_head_wd;
        end
      end
      GntBypass: begin
        o_we = 1'b1;
        o_wa = i_ll_wa;
        o_wd = i_ll_wd;
      end
      GntNone: ;
    endcase
  end

  // A same-cycle WB to the same register is younger, so the entry is born dead.
  assign o_ll_ready  = !i_rst && !w_full;
  assign w_push      = o_ll_ready && w_ll_req && (w_gnt != GntBypass);
  assign w_push_live = !((w_gnt == GntWb) && (i_ll_wa == i_wb_wa));

  always_comb begin
    w_starve_cnt_d = '0;
    w_stall_req_d  = 1'b0;
    if (!w_empty && (w_gnt == GntWb)) begin
      if (r_starve_cnt == STV_W'(STARVE_MAX - 1)) w_stall_req_d = 1'b1;
      else                                        w_starve_cnt_d = r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
      r_stall_req  <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_cnt_d;
      r_stall_req  <= w_stall_req_d;
    end
  end

  assign o_stall_req = r_stall_req;

  wport_pending_fifo #(
    .DEPTH(DEPTH)
  ) u_pending_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (w_push),
    .i_push_wa  (i_ll_wa),
    .i_push_wd  (i_ll_wd),
    .i_push_live(w_push_live),
    .i_pop      (w_gnt == GntDrain),
    .i_kill     (w_gnt == GntWb),
    .i_kill_wa  (i_wb_wa),
    .i_q_rs     (i_q_rs),
    .i_q_rt     (i_q_rt),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_head_live(w_head_live),
    .o_head_wa  (w_head_wa),
    .o_head_wd  (w_head_wd),
    .o_match_rs (o_pend_rs),
    .o_match_rt (o_pend_rt)
  );

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench: a queue-based model checks every output each cycle, while
// literal expectations at key points pin the model to hand-derived values.
module tb_regfile_wport_arbiter;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        ll_valid;
  logic [4:0]  ll_wa;
  logic [31:0] ll_wd;
  logic        ll_ready;
  logic [4:0]  q_rs;
  logic [4:0]  q_rt;
  logic        pend_rs;
  logic        pend_rt;
  logic        stall_req;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        live;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_denied;
  logic        m_stall;
  logic [31:0] dut_rf [32];
  logic        r0_written;
  logic        chk_en;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(
    .DEPTH     (DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wb_we    (wb_we),
    .i_wb_wa    (wb_wa),
    .i_wb_wd    (wb_wd),
    .i_ll_valid (ll_valid),
    .i_ll_wa    (ll_wa),
    .i_ll_wd    (ll_wd),
    .o_ll_ready (ll_ready),
    .i_q_rs     (q_rs),
    .i_q_rt     (q_rt),
    .o_pend_rs  (pend_rs),
    .o_pend_rt  (pend_rt),
    .o_stall_req(stall_req),
    .o_we       (we),
    .o_wa       (wa),
    .o_wd       (wd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_we = en;
    wb_wa = a;
    wb_wd = d;
  endtask

  task automatic set_ll(input logic v, input logic [4:0] a, input logic [31:0] d);
    ll_valid = v;
    ll_wa    = a;
    ll_wd    = d;
  endtask

  // Model: the pending buffer is an ordered list of results; writeback wins,
  // then the oldest result, then a direct pass-through when nothing is waiting.
  initial begin : cmp
    logic        e_we, e_ps, e_pt, wbreq, byp, acc;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    int unsigned n0;
    ent_t        t;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        wbreq = wb_we && (wb_wa != 5'd0);
        byp   = 1'b0;
        e_we  = 1'b0;
        e_wa  = 5'd0;
        e_wd  = 32'd0;
        n0    = mq.size();
        if (!rst) begin
          if (wbreq) begin
            e_we = 1'b1; e_wa = wb_wa; e_wd = wb_wd;
          end else if (n0 > 0) begin
            if (mq[0].live) begin
              e_we = 1'b1; e_wa = mq[0].wa; e_wd = mq[0].wd;
            end
          end else if (ll_valid && ll_wa != 5'd0) begin
            byp  = 1'b1;
            e_we = 1'b1; e_wa = ll_wa; e_wd = ll_wd;
          end
        end
        e_ps = 1'b0;
        e_pt = 1'b0;
        foreach (mq[i]) begin
          if (mq[i].live && mq[i].wa == q_rs && q_rs != 5'd0) e_ps = 1'b1;
          if (mq[i].live && mq[i].wa == q_rt && q_rt != 5'd0) e_pt = 1'b1;
        end
        chk("cyc_we", we, e_we);
        chk("cyc_wa", wa, e_wa);
        chk("cyc_wd", wd, e_wd);
        chk("cyc_ll_ready", ll_ready, !rst && (n0 < DEPTH));
        chk("cyc_pend_rs", pend_rs, e_ps);
        chk("cyc_pend_rt", pend_rt, e_pt);
        chk("cyc_stall_req", stall_req, m_stall);
        if (we === 1'b1) begin
          dut_rf[wa] = wd;
          if (wa == 5'd0) r0_written = 1'b1;
        end
        if (rst) begin
          mq.delete();
          m_denied = 0;
          m_stall  = 1'b0;
        end else begin
          acc = ll_valid && (n0 < DEPTH) && !byp && (ll_wa != 5'd0);
          if (wbreq) begin
            foreach (mq[i]) begin
              if (mq[i].wa == wb_wa) begin
                t = mq[i]; t.live = 1'b0; mq[i] = t;
              end
            end
          end
          if (!wbreq && n0 > 0) void'(mq.pop_front());
          if (acc) mq.push_back('{wa: ll_wa, wd: ll_wd, live: !(wbreq && ll_wa == wb_wa)});
          m_stall = 1'b0;
          if (n0 > 0 && wbreq) begin
            m_denied++;
            if (m_denied == STARVE_MAX) begin
              m_stall  = 1'b1;
              m_denied = 0;
            end
          end else begin
            m_denied = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected summary");
    $fatal(1);
  end

  initial begin
    foreach (dut_rf[i]) dut_rf[i] = 32'd0;
    r0_written = 1'b0;
    m_denied   = 0;
    m_stall    = 1'b0;
    chk_en     = 1'b0;
    rst        = 1'b1;
    set_wb(1'b0, 5'd0, 32'd0);
    set_ll(1'b0, 5'd0, 32'd0);
    q_rs = 5'd0;
    q_rt = 5'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    #1;
    chk("rst_we", we, 0);
    chk("rst_ll_ready", ll_ready, 0);

    // Idle after reset
    tick(); rst = 1'b0; q_rs = 5'd5; q_rt = 5'd4; #1;
    chk("idle_we", we, 0);
    chk("idle_ll_ready", ll_ready, 1);
    chk("idle_stall", stall_req, 0);
    chk("idle_pend_rs", pend_rs, 0);
    chk("idle_pend_rt", pend_rt, 0);

    // Bypass into an empty buffer
    tick(); set_ll(1'b1, 5'd5, 32'hDEAD); #1;
    chk("byp_we", we, 1);
    chk("byp_wa", wa, 5);
    chk("byp_wd", wd, 32'hDEAD);
    tick(); set_ll(1'b0, 5'd0, 32'd0); #1;
    chk("byp_pend_rs", pend_rs, 0);
    chk("byp_ll_ready", ll_ready, 1);

    // Two pushes under continuous writeback, then in-order drain
    tick(); set_wb(1'b1, 5'd7, 32'h70); set_ll(1'b1, 5'd3, 32'h11);
    tick(); set_ll(1'b1, 5'd4, 32'h22);
    tick(); set_ll(1'b0, 5'd0, 32'd0); #1;
    chk("full_ll_ready", ll_ready, 0);
    chk("full_pend_rt", pend_rt, 1);
    chk("full_wa_wb", wa, 7);
    tick(); set_wb(1'b0, 5'd0, 32'd0); #1;
    chk("drain0_we", we, 1);
    chk("drain0_wa", wa, 3);
    chk("drain0_wd", wd, 32'h11);
    tick(); #1;
    chk("drain1_wa", wa, 4);
    chk("drain1_wd", wd, 32'h22);
    tick(); #1;
    chk("drained_we", we, 0);
    chk("drained_ll_ready", ll_ready, 1);

    // WAW kill: younger writeback to r9 supersedes the queued r9
    tick(); set_wb(1'b1, 5'd7, 32'h77); set_ll(1'b1, 5'd9, 32'hAA); q_rs = 5'd9;
    tick(); set_wb(1'b1, 5'd9, 32'hBB); set_ll(1'b0, 5'd0, 32'd0); #1;
    chk("kill_pend_before", pend_rs, 1);
    chk("kill_wb_wd", wd, 32'hBB);
    tick(); set_wb(1'b0, 5'd0, 32'd0); #1;
    chk("kill_pend_after", pend_rs, 0);
    chk("kill_pop_we", we, 0);
    tick(); #1;
    chk("kill_empty_ready", ll_ready, 1);

    // Starvation: one entry denied for STARVE_MAX cycles
    tick(); set_wb(1'b1, 5'd7, 32'h78); set_ll(1'b1, 5'd10, 32'h100);
    for (int i = 1; i <= 4; i++) begin
      tick(); set_ll(1'b0, 5'd0, 32'd0); #1;
      chk("starve_quiet", stall_req, 0);
    end
    tick(); set_wb(1'b0, 5'd0, 32'd0); #1;
    chk("starve_stall", stall_req, 1);
    chk("starve_drain_we", we, 1);
    chk("starve_drain_wa", wa, 10);
    chk("starve_drain_wd", wd, 32'h100);
    tick(); #1;
    chk("starve_released", stall_req, 0);

    // Register zero on both paths
    tick(); set_ll(1'b1, 5'd0, 32'h55); #1;
    chk("r0_ll_ready", ll_ready, 1);
    chk("r0_ll_we", we, 0);
    tick(); set_wb(1'b1, 5'd7, 32'h79); #1;
    chk("r0_wb_ok_wa", wa, 7);
    tick(); set_wb(1'b1, 5'd0, 32'h99); set_ll(1'b0, 5'd0, 32'd0); #1;
    chk("r0_wb_we", we, 0);
    tick(); set_wb(1'b0, 5'd0, 32'd0); #1;
    chk("r0_nothing_queued", ll_ready, 1);

    // Reset with two live entries
    tick(); set_wb(1'b1, 5'd7, 32'h7A); set_ll(1'b1, 5'd11, 32'h1);
    tick(); set_ll(1'b1, 5'd12, 32'h2);
    tick(); set_ll(1'b0, 5'd0, 32'd0); q_rs = 5'd11; q_rt = 5'd12; #1;
    chk("mid_pend_rs", pend_rs, 1);
    chk("mid_pend_rt", pend_rt, 1);
    chk("mid_ll_ready", ll_ready, 0);
    tick(); set_wb(1'b0, 5'd0, 32'd0); rst = 1'b1; #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_ll_ready", ll_ready, 0);
    tick(); rst = 1'b0; #1;
    chk("post_rst_pend_rs", pend_rs, 0);
    chk("post_rst_pend_rt", pend_rt, 0);
    chk("post_rst_ll_ready", ll_ready, 1);
    chk("post_rst_we", we, 0);
    repeat (3) tick();
    #1;

    chk("rf_r3", dut_rf[3], 32'h11);
    chk("rf_r4", dut_rf[4], 32'h22);
    chk("rf_r5", dut_rf[5], 32'hDEAD);
    chk("rf_r9", dut_rf[9], 32'hBB);
    chk("rf_r10", dut_rf[10], 32'h100);
    chk("rf_r11_lost", dut_rf[11], 32'h0);
    chk("rf_r12_lost", dut_rf[12], 32'h0);
    chk("rf_r0_untouched", r0_written, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
